// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM state encoding, access-size codes and alignment check for bsram_lsu
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // size 11 has no legal alignment, so it is reported the same way as a misaligned access
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return size == SIZE_BYTE ? 1'b0 :
               size == SIZE_HALF ? off[0] :
               size == SIZE_WORD ? (off != 2'b00) : 1'b1;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane extract/extend for loads and lane merge for sub-word stores
//   size, off, uns : access size, byte offset in word, zero-extend flag
//   rdata          : word read from memory
//   wdata          : right-aligned store data
//   ld_data        : extended load result
//   st_data        : rdata with the addressed lane(s) replaced by wdata (wdata itself for words)
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        uns,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);

    logic [4:0]  sh;
    logic [15:0] lane;
    logic [31:0] mask;

    always_comb begin
        sh      = {off, 3'b000};
        lane    = 16'(rdata >> sh);
        mask    = (size == SIZE_BYTE ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
        ld_data = size == SIZE_BYTE ? {{24{~uns & lane[7]}}, lane[7:0]} :
                  size == SIZE_HALF ? {{16{~uns & lane[15]}}, lane} : rdata;
        st_data = size == SIZE_WORD ? wdata : (rdata & ~mask) | ((wdata << sh) & mask);
    end

endmodule

// File: rtl/bsram_lsu.sv
// bsram_lsu: load/store front end for one BSRAM, one request in flight, RMW for sub-word stores
//   clock/reset        : single clock, synchronous active-high reset
//   req_*              : valid/ready request channel (byte address, right-aligned store data)
//   resp_*             : valid/ready response channel (extended load data, error flag)
//   mem_*              : BSRAM read/write ports (word addresses, combinational read data)
//   report             : prints state and request registers each cycle in simulation
module bsram_lsu
    import lsu_pkg::*;
#(
    parameter int CORE       = 0,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [ADDR_WIDTH+1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_data,
    output logic                    resp_error,
    output logic                    mem_readEnable,
    output logic [ADDR_WIDTH-1:0]   mem_readAddress,
    input  logic [DATA_WIDTH-1:0]   mem_readData,
    output logic                    mem_writeEnable,
    output logic [ADDR_WIDTH-1:0]   mem_writeAddress,
    output logic [DATA_WIDTH-1:0]   mem_writeData,
    input  logic                    report
);

    state_t                  state_q, state_d;
    logic                    wr_q, wr_d;
    logic                    uns_q, uns_d;
    logic                    err_q, err_d;
    logic [1:0]              size_q, size_d;
    logic [ADDR_WIDTH+1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   ld_data, st_data;

    lsu_align u_align (
        .size    (size_q),
        .off     (addr_q[1:0]),
        .uns     (uns_q),
        .rdata   (mem_readData),
        .wdata   (wdata_q),
        .ld_data (ld_data),
        .st_data (st_data)
    );

    assign req_ready        = state_q == IDLE;
    assign resp_valid       = state_q == RESP;
    assign resp_data        = data_q;
    assign resp_error       = err_q;
    assign mem_readEnable   = state_q == READ && !reset;
    assign mem_writeEnable  = state_q == WRITE && !reset;
    assign mem_readAddress  = mem_readEnable ? addr_q[ADDR_WIDTH+1:2] : '0;
    assign mem_writeAddress = mem_writeEnable ? addr_q[ADDR_WIDTH+1:2] : '0;
    assign mem_writeData    = mem_writeEnable ? wdata_q : '0;

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        uns_d   = uns_q;
        err_d   = err_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        case (state_q)
            IDLE: if (req_valid) begin
                wr_d    = req_write;
                uns_d   = req_unsigned;
                size_d  = req_size;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                data_d  = '0;
                err_d   = misaligned(req_size, req_addr[1:0]);
                state_d = err_d ? RESP : (req_write && req_size == SIZE_WORD) ? WRITE : READ;
            end
            // stores replace their write word with the merged one so WRITE needs no extra register
            READ: if (wr_q) begin
                wdata_d = st_data;
                state_d = WRITE;
            end else begin
                data_d  = ld_data;
                state_d = RESP;
            end
            WRITE: state_d = RESP;
            RESP:  if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (report)
            $display("bsram_lsu[%0d] state=%s wr=%b size=%0d uns=%b addr=%h wdata=%h data=%h err=%b",
                     CORE, state_q.name(), wr_q, size_q, uns_q, addr_q, wdata_q, data_q, err_q);
    end
`endif

endmodule

// File: tb/tb_bsram_lsu.sv
// tb_bsram_lsu: directed self-checking bench for bsram_lsu with a behavioural BSRAM
module tb_bsram_lsu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_error;
    logic        mem_readEnable;
    logic [7:0]  mem_readAddress;
    logic [31:0] mem_readData;
    logic        mem_writeEnable;
    logic [7:0]  mem_writeAddress;
    logic [31:0] mem_writeData;

    logic [31:0] mem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    int          n_wr = 0;
    int          n_en = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          en_base;
    int          wr_base;

    always #5 clock = ~clock;

    bsram_lsu #(.CORE(0), .DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_data        (resp_data),
        .resp_error       (resp_error),
        .mem_readEnable   (mem_readEnable),
        .mem_readAddress  (mem_readAddress),
        .mem_readData     (mem_readData),
        .mem_writeEnable  (mem_writeEnable),
        .mem_writeAddress (mem_writeAddress),
        .mem_writeData    (mem_writeData),
        .report           (1'b0)
    );

    assign mem_readData = mem[mem_readAddress];

    always @(posedge clock) begin
        if (mem_writeEnable) begin
            mem[mem_writeAddress] <= mem_writeData;
            n_wr <= n_wr + 1;
        end else if (pl_en)
            mem[pl_addr] <= pl_data;
        if (mem_writeEnable || mem_readEnable)
            n_en <= n_en + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // presents a request for one cycle; returns #1 after the accepting edge (cycle N+1)
    task automatic req(input logic w, input logic [1:0] sz, input logic u,
                       input logic [9:0] a, input logic [31:0] wd);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        step();
        req_valid = 1'b0;
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    initial begin
        pl_en = 1'b1; pl_addr = 8'h10; pl_data = 32'h8899AABB;
        step();
        pl_addr = 8'hFF; pl_data = 32'hA1B2C3D4;
        step();
        pl_en = 1'b0;
        reset = 1'b0;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp", {29'd0, resp_valid, resp_error, 1'b0}, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_mem", {mem_readEnable, mem_writeEnable, mem_readAddress, mem_writeAddress} | mem_writeData, 32'd0);

        // signed byte load, lane 2 of 0x8899AABB, then held response
        req(1'b0, 2'b00, 1'b0, 10'h042, 32'd0);
        check("lb_ren", 32'(mem_readEnable), 32'd1);
        check("lb_raddr", 32'(mem_readAddress), 32'h10);
        check("lb_n1_valid", 32'(resp_valid), 32'd0);
        step();
        check("lb_valid", 32'(resp_valid), 32'd1);
        check("lb_data", resp_data, 32'hFFFFFF99);
        check("lb_err", 32'(resp_error), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_data", resp_data, 32'hFFFFFF99);
            check("hold_ready", 32'(req_ready), 32'd0);
        end
        consume();
        check("rel_ready", 32'(req_ready), 32'd1);
        check("rel_valid", 32'(resp_valid), 32'd0);

        // unsigned half load at 0x42
        req(1'b0, 2'b01, 1'b1, 10'h042, 32'd0);
        step();
        check("lhu_data", resp_data, 32'h00008899);
        consume();

        // byte store 0x5A at 0x41: read N+1, write N+2, response N+3
        req(1'b1, 2'b00, 1'b0, 10'h041, 32'h0000005A);
        check("sb_ren", 32'(mem_readEnable), 32'd1);
        check("sb_raddr", 32'(mem_readAddress), 32'h10);
        check("sb_n1_wen", 32'(mem_writeEnable), 32'd0);
        step();
        check("sb_wen", 32'(mem_writeEnable), 32'd1);
        check("sb_waddr", 32'(mem_writeAddress), 32'h10);
        check("sb_wdata", mem_writeData, 32'h88995ABB);
        check("sb_n2_valid", 32'(resp_valid), 32'd0);
        step();
        check("sb_valid", 32'(resp_valid), 32'd1);
        check("sb_resp", resp_data, 32'd0);
        consume();
        req(1'b0, 2'b10, 1'b0, 10'h040, 32'd0);
        step();
        check("lw_after_sb", resp_data, 32'h88995ABB);
        consume();

        // misaligned / illegal: immediate error response, no memory access
        en_base = n_en;
        req(1'b0, 2'b01, 1'b0, 10'h043, 32'd0);
        check("mis_h_valid", 32'(resp_valid), 32'd1);
        check("mis_h_err", 32'(resp_error), 32'd1);
        check("mis_h_data", resp_data, 32'd0);
        consume();
        req(1'b1, 2'b10, 1'b0, 10'h042, 32'h12345678);
        check("mis_w_valid", 32'(resp_valid), 32'd1);
        check("mis_w_err", 32'(resp_error), 32'd1);
        consume();
        req(1'b0, 2'b11, 1'b0, 10'h040, 32'd0);
        check("mis_sz_err", 32'(resp_error), 32'd1);
        consume();
        check("mis_no_enables", 32'(n_en - en_base), 32'd0);
        check("mis_mem_intact", mem[16], 32'h88995ABB);

        // reset during READ of a sub-word store
        wr_base = n_wr;
        req(1'b1, 2'b00, 1'b0, 10'h040, 32'h00000011);
        check("rr_ren", 32'(mem_readEnable), 32'd1);
        reset = 1'b1;
        #1;
        check("rr_ren_forced", 32'(mem_readEnable), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("rr_ready", 32'(req_ready), 32'd1);
        check("rr_valid", 32'(resp_valid), 32'd0);
        check("rr_wen", 32'(mem_writeEnable), 32'd0);
        check("rr_data", resp_data, 32'd0);
        step();
        step();
        check("rr_no_write", 32'(n_wr - wr_base), 32'd0);
        check("rr_mem", mem[16], 32'h88995ABB);

        // word store then load at 0x20
        req(1'b1, 2'b10, 1'b0, 10'h020, 32'hDEADBEEF);
        check("sw_wen", 32'(mem_writeEnable), 32'd1);
        check("sw_waddr", 32'(mem_writeAddress), 32'h08);
        check("sw_wdata", mem_writeData, 32'hDEADBEEF);
        step();
        check("sw_valid", 32'(resp_valid), 32'd1);
        consume();
        req(1'b0, 2'b10, 1'b0, 10'h020, 32'd0);
        step();
        check("lw_deadbeef", resp_data, 32'hDEADBEEF);
        consume();

        // top byte address maps to word 0xFF lane 3
        req(1'b0, 2'b00, 1'b1, 10'h3FF, 32'd0);
        check("top_raddr", 32'(mem_readAddress), 32'hFF);
        step();
        check("top_data", resp_data, 32'h000000A1);
        consume();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bsram_lsu.md
# bsram_lsu

Load/store front end that initiates all accesses to one BSRAM data memory on behalf of a core. It accepts byte-addressed load and store requests over a valid/ready handshake and drives the BSRAM read and write ports. It performs byte-lane extraction and sign/zero extension for loads, and read-modify-write for sub-word stores, because BSRAM writes whole words only. It returns one response per request and reports misaligned accesses without touching memory.

## Interface
Parameters:
- CORE, 0, core index printed in report output
- DATA_WIDTH, 32, word width; fixed at 32 (four byte lanes)
- ADDR_WIDTH, 8, BSRAM word-address width; the byte address is ADDR_WIDTH+2 bits

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as misaligned
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0
- req_addr  in  ADDR_WIDTH+2  byte address
- req_wdata  in  32  store data, right-aligned (low bits)
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed
- resp_data  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  misaligned or illegal size
- mem_readEnable  out  1  to BSRAM readEnable
- mem_readAddress  out  ADDR_WIDTH  word address
- mem_readData  in  32  BSRAM combinational read data
- mem_writeEnable  out  1  to BSRAM writeEnable
- mem_writeAddress  out  ADDR_WIDTH  word address
- mem_writeData  out  32  full word to write
- report  in  1  simulation-only $display of state and request registers

## Operation
- States: IDLE, READ, WRITE, RESP.
- In IDLE, a request is accepted when req_valid and req_ready are both high. Accepting captures write, size, unsigned, addr and wdata into registers.
- Misaligned accesses are: half with addr[0]=1; word with addr[1:0]≠0; size=11. A misaligned request goes IDLE→RESP with resp_error=1 and resp_data=0. No memory enable is asserted.
- Load: IDLE→READ→RESP.
  - In READ, mem_readEnable=1 and mem_readAddress=addr[ADDR_WIDTH+1:2].
  - The lane selected by addr[1:0] is extracted (little-endian), extended, and registered into resp_data.
- Word store: IDLE→WRITE→RESP.
  - In WRITE, mem_writeEnable=1 and mem_writeData=wdata.
- Byte/half store: IDLE→READ→WRITE→RESP.
  - READ registers the old word.
  - WRITE writes the old word with the target lane(s) replaced by wdata[7:0] or wdata[15:0].
- RESP holds resp_valid=1 and its data until resp_ready. Leaving RESP returns to IDLE.
- All memory enables are 0 outside READ and WRITE. The enables are also forced to 0 in any cycle where reset is high.

## Timing
- Request accepted at cycle N:
  - Load: resp_valid first high at N+2.
  - Word store: write at N+1, resp_valid at N+2.
  - Sub-word store: read at N+1, write at N+2, resp_valid at N+3.
  - Misaligned: resp_valid at N+1.
- Throughput: at most one request in flight. req_ready=0 from the cycle after acceptance until the cycle after the response handshake.
- Every response handshake happens in RESP. A new request cannot be accepted in the same cycle as a response handshake.
- Reset values: state=IDLE, req_ready=1 (after reset deasserts), resp_valid=0, resp_data=0, resp_error=0, all mem_* outputs 0.
- Reset asserted mid-operation returns to IDLE on the next edge, with no write issued in or after the reset cycle. A pending response is discarded.
- Address wrap: there is none. The top byte address maps to the top word, lane 3.

## Structure
- A shared package `lsu_pkg` holds:
  - state encoding (IDLE=0, READ=1, WRITE=2, RESP=3)
  - size constants SIZE_BYTE, SIZE_HALF, SIZE_WORD
  - the misalignment function
- One sub-module, `lsu_align`. It is purely combinational:
  - load path: lane extract and sign/zero extend
  - store path: lane merge
  - both are driven from the size, offset, unsigned flag and data.
- The main module contains only the FSM, the request/response registers and the report block.

## Test plan
- Preload word 0x10 = 0x8899AABB.
  - Signed byte load at addr 0x42 → resp_data=0xFFFFFF99 at N+2, resp_error=0.
  - Unsigned half load at 0x42 → resp_data=0x00008899.
- Byte store 0x5A at 0x41 → read of word 0x10 at N+1, write of 0x88995ABB at N+2, resp_valid at N+3. A following word load at 0x40 → 0x88995ABB.
- Half load at 0x43 → resp_error=1 at N+1. Word store at 0x42 → resp_error=1. Size=11 → resp_error=1. None of these asserts any mem enable.
- Hold resp_ready=0 for 5 cycles after a load → resp_valid and resp_data stable, req_ready=0 throughout. Release resp_ready → IDLE next cycle, req_ready=1.
- Assert reset in the READ cycle of a sub-word store → no write ever issued, memory word unchanged, all outputs at their reset values the next cycle.
- Back-to-back word store 0xDEADBEEF at 0x20, then word load at 0x20 → the load returns 0xDEADBEEF.
